// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants and types for the coprocessor-0 controller.
// Holds CP0 register numbers, ExcCode values, default handler/PRId values,
// SR and Cause bit positions, and the packed SR view used by the arbiter.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Default parameter values
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE_DEFAULT = 32'h2021_1121;

  // SR bit positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LO   = 10;
  localparam int SR_IM_HI   = 15;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  // Architecturally visible SR fields
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

endpackage

// File: rtl/cp0_exc_arb.sv
// cp0_exc_arb: combinational exception/interrupt arbiter.
// Ports:
//   sr          - current SR fields (IM, EXL, IE)
//   hw_int      - raw external interrupt lines (not the lagged Cause.IP)
//   exc_code_m  - exception code of the M-stage instruction (0 = none)
//   req         - an interrupt or exception must be taken (before reset gating)
//   is_int      - the request is an interrupt
//   exc_code_sel- ExcCode to record (0 for interrupt)
module cp0_exc_arb
  import cp0_pkg::*;
(
  input  sr_t        sr,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_m,
  output logic       req,
  output logic       is_int,
  output logic [4:0] exc_code_sel
);

  logic int_p;
  logic exc_p;

  always_comb begin
    int_p        = sr.ie & ~sr.exl & (|(hw_int & sr.im));
    exc_p        = (exc_code_m != EXC_INT) & ~sr.exl;
    req          = int_p | exc_p;
    is_int       = int_p;
    // Interrupt wins over a simultaneous exception
    exc_code_sel = int_p ? EXC_INT : exc_code_m;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 exception/interrupt controller for the M stage.
// Holds SR, Cause, EPC, PRId and (with CP0_BADVADDR_EN) BadVAddr, drives the
// pipeline-wide flush/redirect request and serves mfc0/mtc0/eret.
// Optional feature macro: CP0_BADVADDR_EN (adds register 8 and bad_vaddr_m).
// Ports:
//   clk, reset        - clock; asynchronous active-low reset
//   cp0_addr/we/wdata - mtc0 register number, write enable, data
//   cp0_rdata         - mfc0 read data, combinational from cp0_addr
//   pc_m, bd_m        - M-stage PC and delay-slot flag
//   exc_code_m        - M-stage exception code (0 = none)
//   eret_m            - eret in M stage
//   hw_int            - level-sensitive interrupt lines
//   bad_vaddr_m       - faulting address (CP0_BADVADDR_EN only)
//   req               - flush all stages and redirect to handler_pc
//   epc_out           - current EPC (eret target)
//   handler_pc        - handler entry PC for the fetch stage
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = PRID_VALUE_DEFAULT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] bad_vaddr_m,
`endif
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        is_int;
`endif

  sr_t         sr;
  logic        arb_req;
  logic [4:0]  exc_sel;
  logic [31:0] pc_al;

  assign sr = '{im: im_q, exl: exl_q, ie: ie_q};

  cp0_exc_arb u_arb (
    .sr           (sr),
    .hw_int       (hw_int),
    .exc_code_m   (exc_code_m),
    .req          (arb_req),
`ifdef CP0_BADVADDR_EN
    .is_int       (is_int),
`else
    .is_int       (),
`endif
    .exc_code_sel (exc_sel)
  );

  // Gating with reset keeps req low while reset is held, even though a
  // pending exception code on the M stage would otherwise request.
  assign req        = reset & arb_req;
  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;
  assign pc_al      = pc_m & 32'hFFFF_FFFC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    if (req) begin
      // req overrides any same-cycle mtc0 and eret
      exl_d      = 1'b1;
      bd_d       = bd_m;
      exc_code_d = exc_sel;
      epc_d      = bd_m ? (pc_al - 32'd4) : pc_al;
`ifdef CP0_BADVADDR_EN
      if (!is_int && (exc_sel == EXC_ADEL || exc_sel == EXC_ADES))
        badvaddr_d = bad_vaddr_m;
`endif
    end else begin
      if (cp0_we && cp0_addr == REG_SR) begin
        im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
        exl_d = cp0_wdata[SR_EXL_BIT];
        ie_d  = cp0_wdata[SR_IE_BIT];
      end
      if (cp0_we && cp0_addr == REG_EPC)
        epc_d = cp0_wdata & 32'hFFFF_FFFC;
      // eret is applied after the mtc0 so it always leaves EXL cleared
      if (eret_m)
        exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= '0;
`endif
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: cp0_rdata = badvaddr_q;
`endif
      REG_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = im_q;
        cp0_rdata[SR_EXL_BIT]        = exl_q;
        cp0_rdata[SR_IE_BIT]         = ie_q;
      end
      REG_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]                = bd_q;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]     = ip_q;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exc_code_q;
      end
      REG_EPC:  cp0_rdata = epc_q;
      REG_PRID: cp0_rdata = PRID_VALUE;
      default:  cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Testbench for cp0_ctrl: directed scenarios followed by randomized cycles,
// all compared against a word-level reference model of the CP0 registers.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr_m;
`endif
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp0_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cp0_addr   (cp0_addr),
    .cp0_we     (cp0_we),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .eret_m     (eret_m),
    .hw_int     (hw_int),
`ifdef CP0_BADVADDR_EN
    .bad_vaddr_m(bad_vaddr_m),
`endif
    .req        (req),
    .epc_out    (epc_out),
    .handler_pc (handler_pc)
  );

  // Reference model: registers held as whole 32-bit words
  logic [31:0] m_sr;     // only bits 15:10, 1, 0 may ever be set
  logic        m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  logic [31:0] m_badv;

  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  function automatic bit m_int_p();
    logic [5:0] im;
    im = 6'((m_sr >> 10) & 32'h3F);
    return m_sr[0] && !m_sr[1] && ((hw_int & im) != 6'd0);
  endfunction

  function automatic bit m_req();
    return reset && (m_int_p() || (exc_code_m != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_badv;
`endif
      5'd12: return m_sr;
      5'd13: return ({31'd0, m_bd} << 31) + ({26'd0, m_ip} << 10) + ({27'd0, m_exc} << 2);
      5'd14: return m_epc;
      5'd15: return 32'h2021_1121;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clear();
    m_sr = 0; m_bd = 0; m_ip = 0; m_exc = 0; m_epc = 0; m_badv = 0;
  endtask

  task automatic m_edge();
    bit r, ip;
    r  = m_req();
    ip = m_int_p();
    if (!reset) begin
      m_clear();
      return;
    end
    if (r) begin
      m_sr  = m_sr | 32'h2;
      m_bd  = bd_m;
      m_exc = ip ? 5'd0 : exc_code_m;
      m_epc = (pc_m & ~32'h3) - (bd_m ? 32'd4 : 32'd0);
`ifdef CP0_BADVADDR_EN
      if (!ip && (exc_code_m == 5'd4 || exc_code_m == 5'd5)) m_badv = bad_vaddr_m;
`endif
    end else begin
      if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_wdata & SR_MASK;
      if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & ~32'h3;
      if (eret_m) m_sr = m_sr & ~32'h2;
    end
    m_ip = hw_int;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs have been set by the caller; check combinational outputs, then clock.
  task automatic step(input string tag);
    if (!reset) m_clear();
    #1;
    check({tag, ".req"}, {31'd0, req}, {31'd0, m_req()});
    check({tag, ".rdata"}, cp0_rdata, m_read(cp0_addr));
    check({tag, ".epc_out"}, epc_out, m_epc);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    cp0_we = 0; cp0_wdata = 0; eret_m = 0; exc_code_m = 0; bd_m = 0;
  endtask

  task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  initial begin
    reset = 0; cp0_addr = 0; cp0_we = 0; cp0_wdata = 0; pc_m = 0; bd_m = 0;
    exc_code_m = 0; eret_m = 0; hw_int = 0;
`ifdef CP0_BADVADDR_EN
    bad_vaddr_m = 0;
`endif
    m_clear();
    @(posedge clk); #1;

    // Reset held with a pending exception code
    exc_code_m = 5'd12;
    for (int i = 0; i < 3; i++) begin
      cp0_addr = 5'(12 + i);
      step("reset");
    end
    read_expect("rst.sr", 5'd12, 32'h0);
    read_expect("rst.cause", 5'd13, 32'h0);
    read_expect("rst.epc", 5'd14, 32'h0);
    read_expect("rst.prid", 5'd15, 32'h2021_1121);
    read_expect("rst.r8", 5'd8, 32'h0);
    check("handler_pc", handler_pc, 32'h0000_4180);
    reset = 1;

    // Exception, then a second one while EXL=1
    exc_code_m = 5'd12; pc_m = 32'h3010; bd_m = 0; cp0_addr = 5'd14;
    #1 check("exc.req", {31'd0, req}, 32'd1);
    step("exc");
    idle();
    read_expect("exc.epc", 5'd14, 32'h0000_3010);
    read_expect("exc.cause", 5'd13, 32'h0000_0030);
    read_expect("exc.sr", 5'd12, 32'h0000_0002);
    exc_code_m = 5'd10;
    #1 check("exc2.req", {31'd0, req}, 32'd0);
    step("exc2");
    idle(); eret_m = 1;
    step("eret1");
    idle();
    read_expect("eret1.sr", 5'd12, 32'h0);

    // Delay slot
    exc_code_m = 5'd10; bd_m = 1; pc_m = 32'h3024;
    step("ds");
    idle();
    read_expect("ds.epc", 5'd14, 32'h0000_3020);
    read_expect("ds.cause", 5'd13, 32'h8000_0028);
    eret_m = 1;
    step("eret2");
    idle();

    // Interrupt wins over a simultaneous AdEL
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    step("mtc0_sr");
    idle();
    read_expect("sr.rd", 5'd12, 32'h0000_0401);
    hw_int = 6'b000001; exc_code_m = 5'd4; pc_m = 32'h5000;
`ifdef CP0_BADVADDR_EN
    bad_vaddr_m = 32'hdead_beef;
`endif
    #1 check("int.req", {31'd0, req}, 32'd1);
    step("int");
    idle();
    read_expect("int.cause", 5'd13, 32'h0000_0400);
    read_expect("int.sr", 5'd12, 32'h0000_0403);
    read_expect("int.r8", 5'd8, 32'h0);

    // eret with interrupt still high: req returns the following cycle
    eret_m = 1;
    #1 check("eret3.req", {31'd0, req}, 32'd0);
    check("eret3.epc_out", epc_out, 32'h0000_5000);
    step("eret3");
    idle();
    #1 check("reint.req", {31'd0, req}, 32'd1);
    step("reint");
    hw_int = 0; eret_m = 1;
    step("eret4");
    idle();

    // BadVAddr capture on AdES
    exc_code_m = 5'd5; pc_m = 32'h6000;
`ifdef CP0_BADVADDR_EN
    bad_vaddr_m = 32'h0000_7ffd;
`endif
    step("ades");
    idle();
`ifdef CP0_BADVADDR_EN
    read_expect("ades.r8", 5'd8, 32'h0000_7ffd);
`else
    read_expect("ades.r8", 5'd8, 32'h0);
`endif

    // Asynchronous reset in the middle of the handler
    cp0_addr = 5'd12; exc_code_m = 5'd12;
    #2 reset = 0;
    #1 check("async.req", {31'd0, req}, 32'd0);
    check("async.sr", cp0_rdata, 32'h0);
    m_clear();
    @(posedge clk); #1;
    reset = 1; idle();

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      cp0_addr  = (k == 0) ? 5'd8 : (k == 1) ? 5'd12 : (k == 2) ? 5'd13 :
                  (k == 3) ? 5'd14 : (k == 4) ? 5'd15 : 5'($urandom_range(0, 31));
      cp0_we    = ($urandom_range(0, 3) == 0);
      cp0_wdata = $urandom;
      pc_m      = $urandom;
      bd_m      = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 7));
      exc_code_m = (k == 1) ? 5'd4 : (k == 2) ? 5'd5 : (k == 3) ? 5'd10 :
                   (k == 4) ? 5'd12 : 5'd0;
      eret_m    = ($urandom_range(0, 3) == 0);
      hw_int    = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
`ifdef CP0_BADVADDR_EN
      bad_vaddr_m = $urandom;
`endif
      reset     = ($urandom_range(0, 49) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception and interrupt controller for the five-stage MIPS pipeline. It consumes the exception code, branch-delay flag and PC that travel with each instruction to the M stage. It drives the pipeline-wide `req` flush/redirect signal that forces the stage registers to the handler address. It also holds SR, Cause, EPC, PRId and, optionally, BadVAddr for `mfc0`/`mtc0`/`eret`.

## Interface
- `PRID_VALUE`, default 32'h2021_1121: read-only value of register 15.
- `HANDLER_PC`, default 32'h0000_4180: handler entry PC; exported for the fetch stage.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; all state is cleared while low.
- `cp0_addr` input 5: register number for `mfc0`/`mtc0`.
- `cp0_we` input 1: `mtc0` in M stage.
- `cp0_wdata` input 32: `mtc0` data.
- `cp0_rdata` output 32: `mfc0` read data; combinational from `cp0_addr`.
- `pc_m` input 32: PC of the M-stage instruction.
- `bd_m` input 1: the M-stage instruction sits in a delay slot.
- `exc_code_m` input 5: M-stage exception code; 0 means none.
- `eret_m` input 1: `eret` in M stage.
- `hw_int` input 6: external interrupt lines, level-sensitive.
- `bad_vaddr_m` input 32: faulting address; present only with `CP0_BADVADDR_EN`.
- `req` output 1: take exception/interrupt; flush all stage registers and redirect to `HANDLER_PC`.
- `epc_out` output 32: current EPC, used as the `eret` target.

## Operation
- **SR (reg 12)**
  - Fields: IM[15:10], EXL[1], IE[0].
  - All other bits read 0.
  - Written by `mtc0`.
- **Cause (reg 13)**
  - Fields: BD[31], IP[15:10], ExcCode[6:2].
  - IP is loaded from `hw_int` every cycle.
  - Not writable by `mtc0`.
- **EPC (reg 14)**: written by `mtc0`; bits [1:0] are forced to 0.
- **PRId (reg 15)**: constant `PRID_VALUE`.
- **Unimplemented numbers**: read 0; writes are ignored.
- **Mode state** is EXL.
  - NORMAL (EXL=0) -> HANDLER (EXL=1) on `req`.
  - HANDLER -> NORMAL on `eret_m`.
- **Interrupt pending**: `int_p = IE & ~EXL & |(hw_int & IM)`.
- **Exception pending**: `exc_p = (exc_code_m != 0) & ~EXL`.
- **Request**: `req = reset & (int_p | exc_p)`. An interrupt has priority over a simultaneous exception.
- **Effects of `req` at the next edge**:
  - EXL <= 1.
  - BD <= `bd_m`.
  - ExcCode <= 0 for an interrupt, else `exc_code_m`.
  - EPC <= `bd_m` ? {`pc_m`[31:2],2'b0} - 4 : {`pc_m`[31:2],2'b0}.
- **Priority at an edge**: `req` overrides a same-cycle `mtc0` to SR or EPC, and overrides `eret_m`.
- **`eret_m` without `req`**: EXL <= 0; nothing else changes.
- **`mtc0` to SR in the same cycle as `eret_m`**: the written value applies first, then EXL is cleared.
- **Exceptions while EXL=1**: ignored; `req` stays 0.

## Timing
- **Reset values**:
  - SR, Cause, EPC and BadVAddr = 0.
  - `req` = 0.
  - `epc_out` = 0.
  - `cp0_rdata` = 0 for every `cp0_addr` except 15.
- **`req`**: combinational in the same cycle as the triggering M-stage state. Stage registers act on it at the following edge.
- **Register updates**: SR, Cause and EPC update on the rising edge after `req`, `mtc0` or `eret_m`.
- **`mfc0` in the cycle after `mtc0`**: returns the new value; no internal bypass is provided.
- **IP latency**: Cause.IP lags `hw_int` by one cycle. `int_p` uses raw `hw_int`.
- **Reset asserted mid-handler**: EXL clears immediately, asynchronously. `req` drops in the same instant.

## Configuration
- Macro: `CP0_BADVADDR_EN`.
- **Defined**:
  - Register 8 (BadVAddr) exists.
  - On `req` with `exc_code_m` = 4 (AdEL) or 5 (AdES), BadVAddr <= `bad_vaddr_m`.
  - Any other cause leaves BadVAddr unchanged.
  - Reads return BadVAddr; `mtc0` is ignored.
- **Undefined**:
  - Port `bad_vaddr_m` is absent.
  - Register 8 reads 0.
  - No flops are inferred.

## Structure
- **Package `cp0_pkg`** holds:
  - Register numbers 8, 12, 13, 14, 15.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - `HANDLER_PC` and `PRID_VALUE` defaults.
  - SR and Cause bit-position constants.
- **Sub-module `cp0_exc_arb`**: combinational.
  - Inputs: SR, `hw_int`, `exc_code_m`.
  - Outputs: `req`, `is_int` and the selected ExcCode.
- **`cp0_ctrl`**: keeps all flops and the read mux.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles with `exc_code_m`=12 -> `req`=0 throughout; reads of regs 12/13/14 return 0; reg 15 returns 32'h2021_1121.
- **Exception**: `exc_code_m`=12, `pc_m`=32'h3010, `bd_m`=0 -> `req`=1 that cycle; next cycle EPC=32'h3010, ExcCode=12, EXL=1; a second exception while EXL=1 gives `req`=0.
- **Delay slot**: `exc_code_m`=10, `bd_m`=1, `pc_m`=32'h3024 -> EPC=32'h3020, Cause.BD=1.
- **Interrupt priority**: `mtc0` SR=32'h0000_0401, then `hw_int`=6'b000001 together with `exc_code_m`=4 -> `req`=1, ExcCode=0; with `CP0_BADVADDR_EN`, BadVAddr is unchanged.
- **eret**: after the interrupt above, `eret_m`=1 -> EXL=0 next cycle; `epc_out` equals the saved EPC; `req` re-asserts the following cycle while `hw_int` stays high.
- **BadVAddr** (macro on): `exc_code_m`=5, `bad_vaddr_m`=32'h0000_7ffd -> reg 8 reads 32'h0000_7ffd. Macro off: reg 8 reads 0.
